// File: rtl/pp_accumulate_pkg.sv
// Shared widths, state encoding and lane helper for the partial-product accumulator.
package pp_pkg;
  localparam int COEF_W = 6;
  localparam int LANES  = 7;
  localparam int IDX_W  = 11;
  localparam int OIDX_W = 10;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic logic [COEF_W-1:0] lane_slice(input logic [LANES*COEF_W-1:0] data,
                                                   input int k);
    return data[k*COEF_W +: COEF_W];
  endfunction
endpackage

// File: rtl/pp_accumulate_if.sv
// Beat input stream and coefficient output stream of the accumulator.
// Handshake: a coefficient moves on a rising edge where out_valid && out_ready;
// the input side has no ready, so a beat is taken whenever in_valid is high.
interface pp_accumulate_if;
  import pp_pkg::*;

  logic                    in_valid;
  logic [IDX_W-1:0]        in_idx;
  logic [LANES*COEF_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [OIDX_W-1:0]       out_idx;
  logic [COEF_W-1:0]       out_coef;
  logic                    out_last;

  modport master (
    output in_valid, in_idx, in_data, out_ready,
    input  out_valid, out_idx, out_coef, out_last
  );

  modport slave (
    input  in_valid, in_idx, in_data, out_ready,
    output out_valid, out_idx, out_coef, out_last
  );
endinterface

// File: rtl/pp_accumulate_lane_fold.sv
// Maps one lane position (in_idx + K) onto a store entry with negacyclic folding.
module pp_lane_fold
  import pp_pkg::*;
#(
  parameter int DEPTH = 784,
  parameter int K     = 0,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [IDX_W-1:0] in_idx,
  output logic [AW-1:0]    entry,
  output logic             negate,
  output logic             out_of_range
);
  localparam logic [IDX_W:0] D1 = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] D2 = (IDX_W+1)'(2*DEPTH);
  localparam logic [IDX_W:0] KP = (IDX_W+1)'(K);

  logic [IDX_W:0] pos;
  assign pos = {1'b0, in_idx} + KP;

  // Upper half folds back with a sign flip because x^DEPTH == -1.
  always_comb begin
    entry        = '0;
    negate       = 1'b0;
    out_of_range = 1'b0;
    if (pos < D1) begin
      entry = AW'(pos);
    end else if (pos < D2) begin
      entry  = AW'(pos - D1);
      negate = 1'b1;
    end else begin
      out_of_range = 1'b1;
    end
  end
endmodule

// File: rtl/pp_accumulate.sv
// Accumulates 7-lane partial-product beats into a negacyclic mod-64 coefficient
// store, then drains the finished polynomial over a valid/ready stream.
module pp_accumulate
  import pp_pkg::*;
#(
  parameter int DEPTH = 784,
  parameter int BEATS = (DEPTH/4)*(DEPTH/4)
) (
  input  logic clk_in,
  input  logic rst_in,
  pp_accumulate_if.slave bus,
  output logic busy,
  output logic err_overrun,
  output logic err_range,
  output state_t dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(BEATS+1);

  state_t              state_q, state_d;
  logic [CW-1:0]       beat_cnt_q;
  logic [OIDX_W-1:0]   drain_idx_q;
  logic [COEF_W-1:0]   store_q [DEPTH];
  logic [COEF_W-1:0]   store_d [DEPTH];
  logic [AW-1:0]       ent [LANES];
  logic [LANES-1:0]    neg;
  logic [LANES-1:0]    oor;
  logic                accept, xfer, last_beat, last_coef;

  for (genvar k = 0; k < LANES; k++) begin : g_fold
    pp_lane_fold #(.DEPTH(DEPTH), .K(k), .AW(AW)) u_fold (
      .in_idx       (bus.in_idx),
      .entry        (ent[k]),
      .negate       (neg[k]),
      .out_of_range (oor[k])
    );
  end

  assign accept    = (state_q == ACCUM) && bus.in_valid;
  assign xfer      = (state_q == DRAIN) && bus.out_ready;
  assign last_beat = (beat_cnt_q == CW'(BEATS-1));
  assign last_coef = (drain_idx_q == OIDX_W'(DEPTH-1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && last_beat) state_d = DRAIN;
      DRAIN:   if (xfer && last_coef)   state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= ACCUM;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      beat_cnt_q  <= '0;
      drain_idx_q <= '0;
    end else begin
      if (accept)
        beat_cnt_q <= last_beat ? '0 : beat_cnt_q + 1'b1;
      if (xfer)
        drain_idx_q <= last_coef ? '0 : drain_idx_q + 1'b1;
    end
  end

  // Lane targets are distinct mod DEPTH, so every lane reads the old value safely.
  always_comb begin
    store_d = store_q;
    if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        if (!oor[k]) begin
          if (neg[k]) store_d[ent[k]] = store_q[ent[k]] - lane_slice(bus.in_data, k);
          else        store_d[ent[k]] = store_q[ent[k]] + lane_slice(bus.in_data, k);
        end
      end
    end
    if (xfer)
      store_d[drain_idx_q[AW-1:0]] = '0;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) store_q <= '{default: '0};
    else         store_q <= store_d;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      err_overrun <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      if ((state_q == DRAIN) && bus.in_valid) err_overrun <= 1'b1;
      if (accept && (|oor))                   err_range   <= 1'b1;
    end
  end

  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_idx   = drain_idx_q;
  assign bus.out_coef  = store_q[drain_idx_q[AW-1:0]];
  assign bus.out_last  = (state_q == DRAIN) && last_coef;
  assign busy          = (state_q == DRAIN);
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_pp_accumulate.sv
// Randomized scoreboard bench for pp_accumulate with DEPTH=8, BEATS=4.
module tb_pp_accumulate;
  import pp_pkg::*;

  localparam int DEPTH = 8;
  localparam int BEATS = 4;
  localparam int W     = OIDX_W + COEF_W + 1;

  logic   clk_in = 1'b0;
  logic   rst_in = 1'b0;
  logic   busy, err_overrun, err_range;
  state_t dbg_state;

  pp_accumulate_if bus();

  pp_accumulate #(.DEPTH(DEPTH), .BEATS(BEATS)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .bus         (bus.slave),
    .busy        (busy),
    .err_overrun (err_overrun),
    .err_range   (err_range),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- reference model state ----------------
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int model [DEPTH];
  int beats_in = 0;
  bit in_drain = 1'b0;
  bit exp_overrun = 1'b0;
  bit exp_range = 1'b0;
  int ready_mode = 0;
  int rcnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, expv, $time);
    end
  endtask

  function automatic logic [LANES*COEF_W-1:0] fill(input int base, input int step);
    logic [LANES*COEF_W-1:0] d;
    d = '0;
    for (int k = 0; k < LANES; k++) d[k*COEF_W +: COEF_W] = COEF_W'((base + step*k) % 64);
    return d;
  endfunction

  function automatic logic [LANES*COEF_W-1:0] rand_data();
    logic [LANES*COEF_W-1:0] d;
    for (int k = 0; k < LANES; k++) d[k*COEF_W +: COEF_W] = COEF_W'($urandom_range(0, 63));
    return d;
  endfunction

  // ---------------- ready driver ----------------
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (rcnt % 3 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      rcnt++;
    end
  end

  // ---------------- beat driver + model ----------------
  task automatic send_beat(input int idx, input logic [LANES*COEF_W-1:0] data);
    bit was_drain;
    int p, lane;
    was_drain    = in_drain;
    bus.in_valid = 1'b1;
    bus.in_idx   = IDX_W'(idx);
    bus.in_data  = data;
    if (was_drain) begin
      exp_overrun = 1'b1;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        p    = idx + k;
        lane = int'(data[k*COEF_W +: COEF_W]);
        if (p < DEPTH)        model[p]       = (model[p] + lane) % 64;
        else if (p < 2*DEPTH) model[p-DEPTH] = (model[p-DEPTH] - lane + 64) % 64;
        else                  exp_range      = 1'b1;
      end
      beats_in++;
      if (beats_in == BEATS) begin
        for (int i = 0; i < DEPTH; i++) begin
          exp_q.push_back({OIDX_W'(i), COEF_W'(model[i]), (i == DEPTH-1)});
          model[i] = 0;
        end
        beats_in = 0;
        in_drain = 1'b1;
      end
    end
    @(posedge clk_in);
    #1;
    bus.in_valid = 1'b0;
    if (!was_drain && in_drain) begin
      check("valid_after_final_beat", bus.out_valid, 1);
      check("busy_after_final_beat", busy, 1);
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk_in);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    check("drain_complete", done, 1);
    in_drain = 1'b0;
  endtask

  task automatic check_flags();
    check("err_overrun", err_overrun, exp_overrun);
    check("err_range", err_range, exp_range);
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_err_overrun", err_overrun, 0);
    check("rst_err_range", err_range, 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_out_coef", bus.out_coef, 0);
    check("rst_state", dbg_state, ACCUM);
  endtask

  task automatic run_random_poly(input int max_idx);
    for (int b = 0; b < BEATS; b++) send_beat($urandom_range(0, max_idx), rand_data());
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_in) begin
    logic [W-1:0] got;
    if (rst_in && bus.out_valid) begin
      got = {bus.out_idx, bus.out_coef, bus.out_last};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output idx=%0d coef=%0d with empty queue at %0t",
                 bus.out_idx, bus.out_coef, $time);
      end else begin
        if (got !== exp_q[0]) begin
          errors++;
          $display("FAIL drain_coef got idx=%0d coef=%0d last=%0d expected idx=%0d coef=%0d last=%0d at %0t",
                   got[W-1 -: OIDX_W], got[COEF_W:1], got[0],
                   exp_q[0][W-1 -: OIDX_W], exp_q[0][COEF_W:1], exp_q[0][0], $time);
        end
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
    bus.in_valid = 1'b0;
    bus.in_idx   = '0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk_in);
    check_reset_outputs();
    rst_in = 1'b1;
    @(negedge clk_in);

    // Basic
    ready_mode = 0;
    send_beat(0, fill(1, 0));
    for (int b = 0; b < BEATS-1; b++) send_beat(0, '0);
    wait_drain();
    check_flags();

    // Negacyclic wrap: lanes 1..7 at idx 4
    send_beat(4, fill(1, 1));
    for (int b = 0; b < BEATS-1; b++) send_beat(0, '0);
    wait_drain();

    // Modulo wrap with back-to-back beats on the same entry
    for (int b = 0; b < BEATS; b++) send_beat(0, (LANES*COEF_W)'(40));
    wait_drain();

    // Backpressure at 1/3 duty, then a zero run must drain all zeros
    ready_mode = 1;
    run_random_poly(2*DEPTH-8);
    wait_drain();
    ready_mode = 0;
    for (int b = 0; b < BEATS; b++) send_beat(0, '0);
    wait_drain();
    check_flags();

    // Overrun: a beat during DRAIN is dropped
    ready_mode = 1;
    run_random_poly(2*DEPTH-8);
    send_beat(2, rand_data());
    wait_drain();
    check_flags();

    // Range: idx 12 pushes lanes 4-6 past 2*DEPTH
    ready_mode = 0;
    send_beat(12, fill(1, 1));
    for (int b = 0; b < BEATS-1; b++) send_beat(0, '0);
    wait_drain();
    check_flags();

    // Random polynomials with random backpressure
    ready_mode = 2;
    for (int r = 0; r < 6; r++) begin
      run_random_poly(2*DEPTH-4);
      wait_drain();
    end
    check_flags();

    // Reset mid-drain at out_idx 3
    ready_mode = 1;
    run_random_poly(2*DEPTH-8);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk_in);
      if (bus.out_valid && bus.out_idx == 3) found = 1'b1;
    end
    check("reached_idx3", found, 1);
    #2 rst_in = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
    beats_in    = 0;
    in_drain    = 1'b0;
    exp_overrun = 1'b0;
    exp_range   = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);

    // Post-reset run
    ready_mode = 0;
    send_beat(4, fill(1, 1));
    send_beat(0, fill(1, 0));
    for (int b = 0; b < BEATS-2; b++) send_beat(0, '0);
    wait_drain();
    check_flags();

    repeat (2) @(negedge clk_in);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
